sd_spi_arbiter: RTL and testbench

Owner/scheduler for the single SD-card SPI bus (sd_mosi, sd_csn) shared by three engines: the initialisation engine, a block-read engine and a block-write engine. It starts initialisation on request, holds off all data traffic until the card reports init_ok, then grants the bus to read/write engines round-robin. It inserts a fixed idle gap (CS high, MOSI high) between owners and aborts any owner that exceeds a timeout. sd_miso is wired to all engines directly and does not pass through this block.

---
 rtl/sd_spi_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sd_spi_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_arbiter.sv
// Single-owner scheduler for the SD-card SPI bus: init engine first, then
// round-robin read/write grants, with a forced idle gap and per-grant timeout.
module sd_spi_arbiter #(
  parameter int unsigned GAP_CYC = 8,
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned TO_W    = 16
) (
  input  logic sd_ck,
  input  logic rst_n,
  input  logic init_req,
  output logic init_start,
  input  logic init_ok,
  input  logic init_mosi,
  input  logic init_csn,
  input  logic rd_req,
  output logic rd_gnt,
  input  logic rd_done,
  input  logic rd_mosi,
  input  logic rd_csn,
  input  logic wr_req,
  output logic wr_gnt,
  input  logic wr_done,
  input  logic wr_mosi,
  input  logic wr_csn,
  input  logic err_clr,
  output logic sd_mosi,
  output logic sd_csn,
  output logic busy,
  output logic err
);

  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    S_UNINIT,
    S_INIT,
    S_READY,
    S_GNT_RD,
    S_GNT_WR,
    S_GAP,
    S_ERR
  } state_t;

  state_t            state, state_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              last_wr, last_wr_nxt;
  logic              to_exp;

  // Expiry is taken on the edge where the count would reach 0, so a grant
  // occupies the bus for exactly TIMEOUT cycles.
  assign to_exp = (to_cnt <= TO_W'(1));

  always_ff @(negedge sd_ck or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_UNINIT;
      to_cnt  <= '0;
      gap_cnt <= '0;
      last_wr <= 1'b1;
    end else begin
      state   <= state_nxt;
      to_cnt  <= to_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      last_wr <= last_wr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    gap_cnt_nxt = gap_cnt;
    last_wr_nxt = last_wr;
    case (state)
      S_UNINIT: begin
        if (init_req) begin
          state_nxt  = S_INIT;
          to_cnt_nxt = TO_W'(TIMEOUT);
        end
      end
      S_INIT: begin
        if (init_ok) begin
          state_nxt   = S_GAP;
          gap_cnt_nxt = GAP_W'(GAP_CYC - 1);
        end else if (to_exp) begin
          state_nxt = S_ERR;
        end else begin
          to_cnt_nxt = to_cnt - TO_W'(1);
        end
      end
      S_READY: begin
        if (rd_req && (!wr_req || last_wr)) begin
          state_nxt   = S_GNT_RD;
          last_wr_nxt = 1'b0;
          to_cnt_nxt  = TO_W'(TIMEOUT);
        end else if (wr_req) begin
          state_nxt   = S_GNT_WR;
          last_wr_nxt = 1'b1;
          to_cnt_nxt  = TO_W'(TIMEOUT);
        end
      end
      S_GNT_RD: begin
        if (rd_done) begin
          state_nxt   = S_GAP;
          gap_cnt_nxt = GAP_W'(GAP_CYC - 1);
        end else if (to_exp) begin
          state_nxt = S_ERR;
        end else begin
          to_cnt_nxt = to_cnt - TO_W'(1);
        end
      end
      S_GNT_WR: begin
        if (wr_done) begin
          state_nxt   = S_GAP;
          gap_cnt_nxt = GAP_W'(GAP_CYC - 1);
        end else if (to_exp) begin
          state_nxt = S_ERR;
        end else begin
          to_cnt_nxt = to_cnt - TO_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = S_READY;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
      end
      S_ERR: begin
        if (err_clr) begin
          state_nxt = S_UNINIT;
        end
      end
      default: state_nxt = S_UNINIT;
    endcase
  end

  // Bus mux is driven straight from the registered owner: no added latency.
  always_comb begin
    sd_mosi = 1'b1;
    sd_csn  = 1'b1;
    case (state)
      S_INIT: begin
        sd_mosi = init_mosi;
        sd_csn  = init_csn;
      end
      S_GNT_RD: begin
        sd_mosi = rd_mosi;
        sd_csn  = rd_csn;
      end
      S_GNT_WR: begin
        sd_mosi = wr_mosi;
        sd_csn  = wr_csn;
      end
      default: ;
    endcase
  end

  assign init_start = (state == S_INIT);
  assign rd_gnt     = (state == S_GNT_RD);
  assign wr_gnt     = (state == S_GNT_WR);
  assign err        = (state == S_ERR);
  assign busy       = (state == S_INIT) || (state == S_GNT_RD) ||
                      (state == S_GNT_WR) || (state == S_GAP);

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Scoreboarded bench for sd_spi_arbiter: status transitions are queued with
// their required edge number and popped by an independent monitor.
module tb_sd_spi_arbiter;

  localparam int unsigned GAP = 8;
  localparam int unsigned TMO = 250;

  logic sd_ck = 1'b0;
  logic rst_n = 1'b1;
  logic init_req = 1'b0, init_ok = 1'b0, init_mosi = 1'b1, init_csn = 1'b1;
  logic rd_req = 1'b0, rd_done = 1'b0, rd_mosi = 1'b1, rd_csn = 1'b1;
  logic wr_req = 1'b0, wr_done = 1'b0, wr_mosi = 1'b1, wr_csn = 1'b1;
  logic err_clr = 1'b0;
  logic init_start, rd_gnt, wr_gnt, sd_mosi, sd_csn, busy, err;

  sd_spi_arbiter #(.GAP_CYC(GAP), .TIMEOUT(TMO), .TO_W(16)) dut (
    .sd_ck(sd_ck), .rst_n(rst_n),
    .init_req(init_req), .init_start(init_start), .init_ok(init_ok),
    .init_mosi(init_mosi), .init_csn(init_csn),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_done(rd_done),
    .rd_mosi(rd_mosi), .rd_csn(rd_csn),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_done(wr_done),
    .wr_mosi(wr_mosi), .wr_csn(wr_csn),
    .err_clr(err_clr), .sd_mosi(sd_mosi), .sd_csn(sd_csn),
    .busy(busy), .err(err)
  );

  always #5 sd_ck = ~sd_ck;

  // Count of active (falling) edges seen so far.
  int unsigned cyc = 0;
  always @(negedge sd_ck) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0]  st;
    logic [31:0] at;
  } ev_t;

  ev_t        exp_q[$];
  int         n_vec = 0;
  int         n_miss = 0;
  logic       mon_en = 1'b0;
  logic [3:0] prev = '0;

  task automatic push_exp(input logic [3:0] st, input int unsigned at);
    ev_t e;
    e.st = st;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(negedge sd_ck);
    #2;
  endtask

  // Hand schedule of the R,W,R,W sequence, relative to the first grant edge.
  function automatic int owner(input int unsigned t);
    if (t < 50) return 1;
    if (t >= 59 && t < 109) return 2;
    if (t >= 118 && t < 168) return 1;
    if (t >= 177 && t < 227) return 2;
    return 0;
  endfunction

  // Monitor: {init_start, rd_gnt, wr_gnt, err} sampled on the inactive edge.
  always @(posedge sd_ck) begin
    logic [3:0] cur;
    ev_t        e;
    if (mon_en) begin
      cur = {init_start, rd_gnt, wr_gnt, err};
      if (cur !== prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL sb_unexpected: status %b at cycle %0d, required no change", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.st || cyc != e.at) begin
            n_miss++;
            $display("FAIL sb_event: status %b at cycle %0d, required %b at cycle %0d",
                     cur, cyc, e.st, e.at);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, g1, g, e, t, bad;
    int          own;

    // Engines drive active levels during reset: the bus must stay idle.
    rst_n = 1'b0;
    init_csn = 1'b0; init_mosi = 1'b0;
    rd_csn = 1'b0; rd_mosi = 1'b0;
    wr_csn = 1'b0; wr_mosi = 1'b0;
    tick(); tick();
    mon_en = 1'b1;
    #1;
    chk("rst_csn", sd_csn, 1);
    chk("rst_mosi", sd_mosi, 1);
    chk("rst_status", {init_start, rd_gnt, wr_gnt, err}, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Data requests in UNINIT are ignored.
    rd_req = 1'b1; wr_req = 1'b1; bad = 0;
    repeat (500) begin
      tick(); #1;
      if (rd_gnt !== 1'b0 || wr_gnt !== 1'b0 || sd_csn !== 1'b1 ||
          sd_mosi !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("uninit_hold", bad, 0);
    rd_req = 1'b0; wr_req = 1'b0;
    init_csn = 1'b1; init_mosi = 1'b1; rd_csn = 1'b1; rd_mosi = 1'b1;
    wr_csn = 1'b1; wr_mosi = 1'b1;

    // Initialisation: 200 cycles in INIT with the bus following init_*.
    tick();
    c0 = cyc;
    init_req = 1'b1;
    push_exp(4'b1000, c0 + 1);
    push_exp(4'b0000, c0 + 201);
    tick();
    init_req = 1'b0;
    #1;
    chk("init_busy", busy, 1);
    bad = 0;
    for (int i = 0; i < 199; i++) begin
      init_csn = i[0]; init_mosi = i[1];
      #1;
      if (sd_csn !== init_csn || sd_mosi !== init_mosi) bad++;
      tick();
    end
    chk("init_bus_follow", bad, 0);
    init_ok = 1'b1;
    tick();
    init_csn = 1'b0; init_mosi = 1'b0; rd_csn = 1'b0; rd_mosi = 1'b0;
    wr_csn = 1'b0; wr_mosi = 1'b0;
    bad = 0;
    repeat (GAP) begin
      #1;
      if (sd_csn !== 1'b1 || sd_mosi !== 1'b1 || busy !== 1'b1) bad++;
      tick();
    end
    chk("init_gap_idle", bad, 0);
    #1;
    chk("ready_busy", busy, 0);
    chk("ready_bus", {sd_csn, sd_mosi}, 2'b11);
    init_csn = 1'b1; init_mosi = 1'b1; wr_mosi = 1'b1;

    // Tied requests alternate R,W,R,W with a 9-cycle idle gap between owners.
    rd_req = 1'b1; wr_req = 1'b1;
    g1 = cyc + 1;
    push_exp(4'b0100, g1);       push_exp(4'b0000, g1 + 50);
    push_exp(4'b0010, g1 + 59);  push_exp(4'b0000, g1 + 109);
    push_exp(4'b0100, g1 + 118); push_exp(4'b0000, g1 + 168);
    push_exp(4'b0010, g1 + 177); push_exp(4'b0000, g1 + 227);
    bad = 0;
    for (int k = 0; k < 229; k++) begin
      tick();
      t = cyc - g1;
      own = owner(t);
      rd_csn = (own == 1) ? 1'b0 : 1'b1;
      rd_mosi = 1'b0;
      wr_csn = (own == 2) ? 1'b0 : 1'b1;
      wr_mosi = t[0];
      rd_done = (t == 49 || t == 167);
      wr_done = (t == 108 || t == 226);
      if (t >= 228) begin
        rd_req = 1'b0; wr_req = 1'b0;
      end
      #1;
      if (own == 1) begin
        if (sd_csn !== 1'b0 || sd_mosi !== 1'b0) bad++;
      end else if (own == 2) begin
        if (sd_csn !== 1'b0 || sd_mosi !== t[0]) bad++;
      end else begin
        if (sd_csn !== 1'b1 || sd_mosi !== 1'b1) bad++;
      end
    end
    chk("rr_bus", bad, 0);
    rd_done = 1'b0; wr_done = 1'b0;
    rd_csn = 1'b1; rd_mosi = 1'b1; wr_csn = 1'b1; wr_mosi = 1'b1;

    // Read grant without done: ERR after exactly TMO cycles.
    repeat (8) tick();
    rd_req = 1'b1;
    g = cyc + 1;
    push_exp(4'b0100, g);
    push_exp(4'b0001, g + TMO);
    tick();
    rd_req = 1'b0;
    rd_csn = 1'b0;
    repeat (TMO - 1) tick();
    #1;
    chk("to_last_gnt_cycle", rd_gnt, 1);
    tick();
    #1;
    chk("to_err", err, 1);
    chk("to_rd_gnt", rd_gnt, 0);
    chk("to_busy", busy, 0);
    chk("to_bus_idle", sd_csn, 1);
    rd_csn = 1'b1;

    // err_clr -> UNINIT, init_req -> INIT, held init_ok leaves INIT at once.
    err_clr = 1'b1;
    e = cyc;
    push_exp(4'b0000, e + 1);
    push_exp(4'b1000, e + 2);
    push_exp(4'b0000, e + 3);
    tick();
    err_clr = 1'b0;
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    tick();
    #1;
    chk("reinit_gap_busy", busy, 1);
    repeat (GAP) tick();
    #1;
    chk("reinit_ready_busy", busy, 0);
    chk("reinit_err", err, 0);

    // Done coinciding with expiry: done wins.
    rd_req = 1'b1;
    g = cyc + 1;
    push_exp(4'b0100, g);
    push_exp(4'b0000, g + TMO);
    tick();
    rd_req = 1'b0;
    repeat (TMO - 1) tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    #1;
    chk("tie_err", err, 0);
    chk("tie_gap_busy", busy, 1);
    repeat (GAP) tick();
    #1;
    chk("tie_ready_busy", busy, 0);
    chk("tie_ready_err", err, 0);

    // Asynchronous reset in the middle of a write grant.
    wr_req = 1'b1;
    push_exp(4'b0010, cyc + 1);
    tick();
    wr_csn = 1'b0; wr_mosi = 1'b0;
    repeat (5) tick();
    #1;
    chk("wr_bus_owned", {sd_csn, sd_mosi}, 2'b00);
    push_exp(4'b0000, cyc);
    rst_n = 1'b0;
    #1;
    chk("arst_csn", sd_csn, 1);
    chk("arst_mosi", sd_mosi, 1);
    chk("arst_wr_gnt", wr_gnt, 0);
    chk("arst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    #1;
    chk("post_rst_no_gnt", wr_gnt, 0);
    chk("post_rst_csn", sd_csn, 1);
    wr_req = 1'b0; wr_csn = 1'b1; wr_mosi = 1'b1;
    tick(); tick();
    chk("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
